screen_sequencer: RTL
=====================

Name: screen_sequencer

Overview:
Top-level display sequencer for BrickBreaker. It walks the game through title → play → win/lose → title, and kicks the picture drawer for each full-screen image. It owns the single VGA plot port, muxing it between the picture drawer and the live game renderer. It also realigns the picture drawer's registered colour with its combinational x/y and clips out-of-screen addresses.

Parameters:
SCR_W, 160, visible width in pixels; picture pixels with x >= SCR_W are not plotted
SCR_H, 120, visible height; picture pixels with y >= SCR_H are not plotted
KICK_TIMEOUT, 8, cycles to wait for pic_drawing to rise after pic_enable before re-kicking

Ports:
clk  in  1  system clock
resetn  in  1  reset; synchronous, active-low
start_key  in  1  player start button, synchronised level, active-high
game_won  in  1  game logic: all bricks cleared (level)
game_lost  in  1  game logic: ball lost, no lives (level)
pic_drawing  in  1  picture drawer busy flag
pic_x  in  10  picture drawer pixel x (valid same cycle as address)
pic_y  in  10  picture drawer pixel y
pic_colour  in  3  picture colour, valid one cycle after pic_x/pic_y
game_plot  in  1  renderer pixel write strobe
game_x  in  8  renderer pixel x
game_y  in  7  renderer pixel y
game_colour  in  3  renderer pixel colour
pic_enable  out  1  one-cycle start pulse to picture drawer
screen_select  out  2  0 title, 1 win, 2 lose (3 never driven)
game_run  out  1  high while game logic may advance
vga_plot  out  1  VGA write enable
vga_x  out  8  VGA x
vga_y  out  7  VGA y
vga_colour  out  3  VGA colour

Behaviour:
- Reset: all outputs 0, state KICK, screen_select 0, internal flags/counters 0. Reset mid-draw abandons the image; no plot in the cycle after reset.
- start_key is rising-edge detected via a registered copy; holding the key produces one event.
- FSM states:
  - KICK: pic_enable=1 for exactly one cycle, clear seen flag and timeout counter → DRAW.
  - DRAW: count cycles. If pic_drawing has not been seen high after KICK_TIMEOUT cycles → KICK (same screen_select). Set seen flag on first pic_drawing=1. Once seen=1, pic_drawing=0 and pipeline valid=0 → HOLD.
  - HOLD: start_key edge → PLAY if screen_select=0, else screen_select←0 → KICK.
  - PLAY: game_run=1. game_won → screen_select←1 → KICK. Else game_lost → screen_select←2 → KICK. Won has priority when both are high in the same cycle. game_run drops in the same cycle the state leaves PLAY.
- Picture pipeline (DRAW only): stage registers px_d, py_d, valid_d ← pic_x, pic_y, pic_drawing. Output cycle: vga_plot=valid_d & (px_d<SCR_W) & (py_d<SCR_H); vga_x=px_d[7:0], vga_y=py_d[6:0], vga_colour=pic_colour. Total plot latency is one cycle from address to output registers. The last pixel is plotted in the cycle after pic_drawing falls.
- PLAY path: vga_* ← game_* registered (1-cycle latency); game_plot is ignored outside PLAY.
- Outside DRAW/PLAY, vga_plot=0; vga_x/y/colour hold their last values.
- screen_select changes only on entry to KICK and is stable throughout DRAW, so the drawer's colour mux is never switched mid-image.
- start_key edges are ignored in KICK, DRAW and PLAY.

Test Plan:
1. Reset, model drawer asserting pic_drawing 1 cycle after enable, sweeping addresses 0..32767 → exactly one pic_enable pulse. vga_plot high exactly 19200 times, first plot (0,0) two cycles after enable, last plot (159,119). No plot for y>=120. → HOLD.
2. In HOLD, press start_key held 50 cycles → single transition to PLAY, game_run=1. game_plot at (10,20,colour 5) → vga_plot with (10,20,5) one cycle later.
3. In PLAY, assert game_won and game_lost in the same cycle → screen_select=1, one pic_enable pulse, game_run=0 that cycle. Win image drawn. start_key → screen_select=0, title redrawn.
4. Drawer never responds → pic_enable re-pulses every KICK_TIMEOUT+1 cycles, vga_plot stays 0. Drawer then responds → normal draw completes.
5. resetn low mid-DRAW at address 5000 → next cycle all outputs 0. After release, title redraw restarts with a fresh pic_enable.
6. game_plot pulses during DRAW/HOLD → never reach vga_plot. start_key during DRAW → ignored; HOLD still requires a new press.

Source files
------------

// File: rtl/screen_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : screen_sequencer
// Description : BrickBreaker display sequencer. Walks title -> play -> win/lose
//               -> title, kicks the picture drawer and owns the VGA plot port.
// Revision    : 1.0 - initial release
// ============================================================================

module screen_sequencer #(
    parameter int SCR_W        = 160,
    parameter int SCR_H        = 120,
    parameter int KICK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_key,
    input  logic       game_won,
    input  logic       game_lost,
    input  logic       pic_drawing,
    input  logic [9:0] pic_x,
    input  logic [9:0] pic_y,
    input  logic [2:0] pic_colour,
    input  logic       game_plot,
    input  logic [7:0] game_x,
    input  logic [6:0] game_y,
    input  logic [2:0] game_colour,
    output logic       pic_enable,
    output logic [1:0] screen_select,
    output logic       game_run,
    output logic       vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour
);

    localparam int              CNT_W    = $clog2(KICK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KICK_TIMEOUT - 1);
    localparam logic [9:0]      W_LIM    = 10'(SCR_W);
    localparam logic [9:0]      H_LIM    = 10'(SCR_H);

    localparam logic [1:0] SEL_TITLE = 2'd0;
    localparam logic [1:0] SEL_WIN   = 2'd1;
    localparam logic [1:0] SEL_LOSE  = 2'd2;

    typedef enum logic [1:0] {
        ST_KICK = 2'd0,
        ST_DRAW = 2'd1,
        ST_HOLD = 2'd2,
        ST_PLAY = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic             pic_enable_q, pic_enable_d;
    logic             key_q, key_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // picture address stage, aligned with the drawer's registered colour
    logic [9:0]       px_q, px_d;
    logic [9:0]       py_q, py_d;
    logic             pvalid_q, pvalid_d;

    logic             gplot_q, gplot_d;
    logic [7:0]       gx_q, gx_d;
    logic [6:0]       gy_q, gy_d;
    logic [2:0]       gcol_q, gcol_d;

    logic [7:0]       hold_x_q, hold_x_d;
    logic [6:0]       hold_y_q, hold_y_d;
    logic [2:0]       hold_col_q, hold_col_d;

    logic             key_edge;
    logic             pic_hit;

    assign key_edge = start_key & ~key_q;
    assign pic_hit  = pvalid_q & (px_q < W_LIM) & (py_q < H_LIM);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        seen_d       = seen_q;
        cnt_d        = cnt_q;
        key_d        = start_key;
        pic_enable_d = (state_q == ST_KICK);

        case (state_q)
            ST_KICK: begin
                seen_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                if (pic_drawing) begin
                    seen_d = 1'b1;
                end
                if (seen_q) begin
                    // wait for the last staged pixel to drain before leaving
                    if (!pic_drawing && !pvalid_q) begin
                        state_d = ST_HOLD;
                    end
                end else if (!pic_drawing) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_KICK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (key_edge) begin
                    if (sel_q == SEL_TITLE) begin
                        state_d = ST_PLAY;
                    end else begin
                        sel_d   = SEL_TITLE;
                        state_d = ST_KICK;
                    end
                end
            end
            ST_PLAY: begin
                if (game_won) begin
                    sel_d   = SEL_WIN;
                    state_d = ST_KICK;
                end else if (game_lost) begin
                    sel_d   = SEL_LOSE;
                    state_d = ST_KICK;
                end
            end
            default: begin
                state_d = ST_KICK;
            end
        endcase
    end

    always_comb begin
        px_d     = pic_x;
        py_d     = pic_y;
        pvalid_d = (state_q == ST_DRAW) & pic_drawing;
        gplot_d  = (state_q == ST_PLAY) & game_plot;
        gx_d     = game_x;
        gy_d     = game_y;
        gcol_d   = game_colour;
    end

    // Only real writes update x/y/colour; otherwise the last values are held.
    always_comb begin
        vga_plot   = 1'b0;
        vga_x      = hold_x_q;
        vga_y      = hold_y_q;
        vga_colour = hold_col_q;
        if (state_q == ST_DRAW) begin
            vga_plot = pic_hit;
            if (pic_hit) begin
                vga_x      = px_q[7:0];
                vga_y      = py_q[6:0];
                vga_colour = pic_colour;
            end
        end else if (state_q == ST_PLAY) begin
            vga_plot = gplot_q;
            if (gplot_q) begin
                vga_x      = gx_q;
                vga_y      = gy_q;
                vga_colour = gcol_q;
            end
        end
        hold_x_d   = vga_x;
        hold_y_d   = vga_y;
        hold_col_d = vga_colour;
    end

    assign pic_enable    = pic_enable_q;
    assign screen_select = sel_q;
    assign game_run      = (state_q == ST_PLAY) & ~game_won & ~game_lost;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_KICK;
            sel_q        <= SEL_TITLE;
            pic_enable_q <= 1'b0;
            key_q        <= 1'b0;
            seen_q       <= 1'b0;
            cnt_q        <= '0;
            px_q         <= '0;
            py_q         <= '0;
            pvalid_q     <= 1'b0;
            gplot_q      <= 1'b0;
            gx_q         <= '0;
            gy_q         <= '0;
            gcol_q       <= '0;
            hold_x_q     <= '0;
            hold_y_q     <= '0;
            hold_col_q   <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            pic_enable_q <= pic_enable_d;
            key_q        <= key_d;
            seen_q       <= seen_d;
            cnt_q        <= cnt_d;
            px_q         <= px_d;
            py_q         <= py_d;
            pvalid_q     <= pvalid_d;
            gplot_q      <= gplot_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            gcol_q       <= gcol_d;
            hold_x_q     <= hold_x_d;
            hold_y_q     <= hold_y_d;
            hold_col_q   <= hold_col_d;
        end
    end

endmodule

`default_nettype wire
